pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage.sv | 121 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Two-slot skid buffer between pipeline stages, carrying a payload and a control field.
// Latency 1 cycle; full throughput of 1 entry/cycle while downstream keeps accepting.
// Back-pressure: in_ready comes from registered state only and drops when both slots hold entries.
module pipe_skid_stage #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              clr_stats,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] head_data, head_data_nxt;
    logic [DATA_W-1:0] skid_data, skid_data_nxt;
    logic [CTRL_W-1:0] head_ctrl, head_ctrl_nxt;
    logic [CTRL_W-1:0] skid_ctrl, skid_ctrl_nxt;
    logic              in_fire;
    logic              out_fire;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = head_data;
    assign out_ctrl  = out_valid ? head_ctrl : '0;
    assign occupancy = state;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_nxt     = state;
        head_data_nxt = head_data;
        head_ctrl_nxt = head_ctrl;
        skid_data_nxt = skid_data;
        skid_ctrl_nxt = skid_ctrl;
        if (flush) begin
            // Control cleared so a killed entry can never commit side effects.
            state_nxt     = EMPTY;
            head_ctrl_nxt = '0;
            skid_ctrl_nxt = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        head_data_nxt = in_data;
                        head_ctrl_nxt = in_ctrl;
                        state_nxt     = ONE;
                    end
                end
                ONE: begin
                    case ({in_fire, out_fire})
                        2'b11: begin
                            head_data_nxt = in_data;
                            head_ctrl_nxt = in_ctrl;
                        end
                        2'b10: begin
                            skid_data_nxt = in_data;
                            skid_ctrl_nxt = in_ctrl;
                            state_nxt     = FULL;
                        end
                        2'b01:   state_nxt = EMPTY;
                        default: state_nxt = ONE;
                    endcase
                end
                FULL: begin
                    if (out_fire) begin
                        head_data_nxt = skid_data;
                        head_ctrl_nxt = skid_ctrl;
                        state_nxt     = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= EMPTY;
            head_data <= '0;
            head_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state     <= state_nxt;
            head_data <= head_data_nxt;
            head_ctrl <= head_ctrl_nxt;
            skid_data <= skid_data_nxt;
            skid_ctrl <= skid_ctrl_nxt;
        end
    end

    // Counts cycles where an entry is presented but refused; saturates instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (clr_stats) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_pipe_skid_stage;

    localparam int DW = 16;
    localparam int CW = 6;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic          flush;
    logic          clr_stats;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: ordered list of held entries {ctrl, data} and a stall count.
    logic [CW+DW-1:0] mq[$];
    int               mstall = 0;
    logic [CW+DW-1:0] mhead;
    bit               m_in_fire;
    bit               m_out_fire;

    pipe_skid_stage #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .flush     (flush),
        .clr_stats (clr_stats),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic fl, input logic clr);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        clr_stats = clr;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_in_ready"},  in_ready,  1);
        check({tag, "_occupancy"}, occupancy, 0);
        check({tag, "_out_data"},  out_data,  0);
        check({tag, "_out_ctrl"},  out_ctrl,  0);
        check({tag, "_stall_cnt"}, stall_cnt, 0);
    endtask

    // Compare against the model mid-cycle, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        if (reset) begin
            check_reset_outputs("m_rst");
            mq.delete();
            mstall = 0;
        end else begin
            check("m_occupancy", occupancy, mq.size());
            check("m_in_ready",  in_ready,  mq.size() < 2);
            check("m_out_valid", out_valid, mq.size() > 0);
            check("m_stall_cnt", stall_cnt, mstall);
            if (mq.size() > 0) begin
                mhead = mq[0];
                check("m_out_data", out_data, mhead[DW-1:0]);
                check("m_out_ctrl", out_ctrl, mhead[CW+DW-1:DW]);
            end else begin
                check("m_out_ctrl_idle", out_ctrl, 0);
            end
            m_in_fire  = in_valid && (mq.size() < 2);
            m_out_fire = (mq.size() > 0) && out_ready;
            if (clr_stats)
                mstall = 0;
            else if ((mq.size() > 0) && !out_ready && mstall < (2**NW - 1))
                mstall++;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_out_fire) void'(mq.pop_front());
                if (m_in_fire) mq.push_back({in_ctrl, in_data});
            end
        end
    end

    initial begin
        int pr;
        reset = 1'b1;
        in_valid = 0; in_data = '0; in_ctrl = '0;
        out_ready = 0; flush = 0; clr_stats = 0;
        #2;
        check_reset_outputs("rst0");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Streaming with downstream always ready.
        cyc(1, 16'h11, 6'h01, 1, 0, 0);
        cyc(1, 16'h22, 6'h02, 1, 0, 0);
        @(negedge clk);
        check("s1_data0", out_data, 16'h11);
        check("s1_occ0", occupancy, 1);
        check("s1_rdy0", in_ready, 1);
        cyc(1, 16'h33, 6'h03, 1, 0, 0);
        @(negedge clk);
        check("s1_data1", out_data, 16'h22);
        check("s1_ctrl1", out_ctrl, 6'h02);
        cyc(0, 16'h0, 6'h0, 1, 0, 0);
        @(negedge clk);
        check("s1_data2", out_data, 16'h33);
        check("s1_occ2", occupancy, 1);
        cyc(0, 16'h0, 6'h0, 1, 0, 0);
        @(negedge clk);
        check("s1_empty", out_valid, 0);

        // Fill both slots, hold a third, then drain in order.
        cyc(1, 16'h0A, 6'h0A, 0, 0, 0);
        cyc(1, 16'h0B, 6'h0B, 0, 0, 0);
        cyc(1, 16'h0C, 6'h0C, 0, 0, 0);
        @(negedge clk);
        check("s2_occ_full", occupancy, 2);
        check("s2_rdy_low", in_ready, 0);
        check("s2_head_a", out_data, 16'h0A);
        cyc(1, 16'h0C, 6'h0C, 0, 0, 0);
        @(negedge clk);
        check("s2_hold_occ", occupancy, 2);
        cyc(1, 16'h0C, 6'h0C, 1, 0, 0);
        @(negedge clk);
        check("s2_out_a", out_data, 16'h0A);
        cyc(1, 16'h0C, 6'h0C, 1, 0, 0);
        @(negedge clk);
        check("s2_out_b", out_data, 16'h0B);
        check("s2_occ_b", occupancy, 1);
        cyc(0, 16'h0, 6'h0, 1, 0, 0);
        @(negedge clk);
        check("s2_out_c", out_data, 16'h0C);
        check("s2_ctrl_c", out_ctrl, 6'h0C);
        cyc(0, 16'h0, 6'h0, 1, 0, 0);
        @(negedge clk);
        check("s2_drained", occupancy, 0);

        // Flush while full, with a simultaneous push that must vanish.
        cyc(1, 16'h55, 6'h3F, 0, 0, 0);
        cyc(1, 16'h66, 6'h3F, 0, 0, 0);
        cyc(1, 16'h77, 6'h3F, 0, 1, 0);
        @(negedge clk);
        check("s3_pre_occ", occupancy, 2);
        check("s3_pre_ctrl", out_ctrl, 6'h3F);
        cyc(0, 16'h0, 6'h0, 1, 0, 0);
        @(negedge clk);
        check("s3_occ", occupancy, 0);
        check("s3_valid", out_valid, 0);
        check("s3_ctrl", out_ctrl, 0);
        cyc(0, 16'h0, 6'h0, 1, 0, 0);
        @(negedge clk);
        check("s3_no_ghost", out_valid, 0);

        // Stall counter saturation and clear.
        cyc(1, 16'h99, 6'h01, 0, 0, 1);
        repeat (20) cyc(0, 16'h0, 6'h0, 0, 0, 0);
        @(negedge clk);
        check("s4_sat", stall_cnt, 15);
        cyc(0, 16'h0, 6'h0, 0, 0, 0);
        @(negedge clk);
        check("s4_sat_hold", stall_cnt, 15);
        cyc(0, 16'h0, 6'h0, 0, 0, 1);
        cyc(0, 16'h0, 6'h0, 0, 0, 0);
        @(negedge clk);
        check("s4_clr", stall_cnt, 0);
        cyc(0, 16'h0, 6'h0, 0, 0, 0);
        @(negedge clk);
        check("s4_recount", stall_cnt, 1);
        cyc(0, 16'h0, 6'h0, 1, 0, 0);
        cyc(0, 16'h0, 6'h0, 1, 0, 0);

        // Asynchronous reset mid-cycle while full.
        cyc(1, 16'h01, 6'h11, 0, 0, 0);
        cyc(1, 16'h02, 6'h12, 0, 0, 0);
        cyc(0, 16'h0, 6'h0, 0, 0, 0);
        @(negedge clk);
        check("s5_full", occupancy, 2);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset_outputs("s5_async");
        @(posedge clk);
        #1 reset = 1'b0;
        in_valid = 1; in_data = 16'h42; in_ctrl = 6'h05; out_ready = 1;
        @(negedge clk);
        check("s5_pre_push", occupancy, 0);
        cyc(0, 16'h0, 6'h0, 1, 0, 0);
        @(negedge clk);
        check("s5_lat1_data", out_data, 16'h42);
        check("s5_lat1_occ", occupancy, 1);

        // Randomized traffic with varying downstream readiness.
        pr = 50;
        for (int i = 0; i < 10000; i++) begin
            if (i % 500 == 0) pr = $urandom_range(5, 95);
            cyc($urandom_range(0, 99) < 60, 16'($urandom), 6'($urandom),
                $urandom_range(0, 99) < pr,
                $urandom_range(0, 63) == 0,
                $urandom_range(0, 49) == 0);
        end
        cyc(0, 16'h0, 6'h0, 1, 0, 0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
